// File: rtl/duck_flight_if.sv
// Spawn/control inputs and sprite outputs of the duck flight controller.
// slave is the controller side, master is the driver/consumer side.
interface duck_flight_if;
    logic [1:0] state;
    logic       frame_tick;
    logic       spawn;
    logic [9:0] spawn_x;
    logic [9:0] spawn_y;
    logic       hit;
    logic       timeout;
    logic [9:0] duck_x;
    logic [9:0] duck_y;
    logic       duck_visible;
    logic       duck_falling;
    logic       dir_left;
    logic       escaped;
    logic       landed;

    modport slave (
        input  state, frame_tick, spawn, spawn_x, spawn_y, hit, timeout,
        output duck_x, duck_y, duck_visible, duck_falling, dir_left, escaped, landed
    );

    modport master (
        output state, frame_tick, spawn, spawn_x, spawn_y, hit, timeout,
        input  duck_x, duck_y, duck_visible, duck_falling, dir_left, escaped, landed
    );
endinterface

// File: rtl/duck_flight_ctrl.sv
// Duck sprite flight controller: latches spawn coordinates and animates the duck once
// per video frame through fly/bounce, fall-when-shot and fly-off-the-top phases.
module duck_flight_ctrl #(
    parameter int unsigned SCREEN_W  = 960,
    parameter int unsigned SCREEN_H  = 704,
    parameter int unsigned DUCK_W    = 64,
    parameter int unsigned DUCK_H    = 64,
    parameter int unsigned Y_MIN     = 96,
    parameter int unsigned STEP_X    = 4,
    parameter int unsigned STEP_Y    = 2,
    parameter int unsigned FALL_STEP = 6
) (
    input  logic          clk,
    input  logic          rst,
    duck_flight_if.slave  bus
);

    localparam logic [10:0] XMax  = 11'(SCREEN_W - DUCK_W);
    localparam logic [10:0] YMax  = 11'(SCREEN_H - DUCK_H);
    localparam logic [10:0] YMin  = 11'(Y_MIN);
    localparam logic [10:0] StepX = 11'(STEP_X);
    localparam logic [10:0] StepY = 11'(STEP_Y);
    localparam logic [10:0] FallS = 11'(FALL_STEP);
    localparam logic [1:0]  Play  = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StFly,
        StFall,
        StEscape
    } fly_state_e;

    fly_state_e state_q, state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       visible_q, visible_d;
    logic       falling_q, falling_d;
    logic       left_q, left_d;
    logic       up_q, up_d;
    logic       escaped_q, escaped_d;
    logic       landed_q, landed_d;
    logic       spawn_d_q;

    // 11-bit working copies so sums and differences never wrap.
    logic [10:0] x_w, y_w, sx_w, sy_w;
    logic [10:0] x_fly, y_fly;
    logic        left_fly, up_fly;
    logic [10:0] x_load, y_load;

    assign x_w  = {1'b0, x_q};
    assign y_w  = {1'b0, y_q};
    assign sx_w = {1'b0, bus.spawn_x};
    assign sy_w = {1'b0, bus.spawn_y};

    // Spawn coordinates clamped into the sprite's legal range.
    always_comb begin
        x_load = (sx_w > XMax) ? XMax : sx_w;
        if (sy_w < YMin) begin
            y_load = YMin;
        end else if (sy_w > YMax) begin
            y_load = YMax;
        end else begin
            y_load = sy_w;
        end
    end

    // One frame of flight with wall bounce on each axis.
    always_comb begin
        x_fly    = x_w;
        left_fly = left_q;
        if (left_q) begin
            if (x_w < StepX) begin
                x_fly    = '0;
                left_fly = 1'b0;
            end else begin
                x_fly = x_w - StepX;
            end
        end else begin
            if (x_w + StepX > XMax) begin
                x_fly    = XMax;
                left_fly = 1'b1;
            end else begin
                x_fly = x_w + StepX;
            end
        end

        y_fly  = y_w;
        up_fly = up_q;
        if (up_q) begin
            if (y_w < YMin + StepY) begin
                y_fly  = YMin;
                up_fly = 1'b0;
            end else begin
                y_fly = y_w - StepY;
            end
        end else begin
            if (y_w + StepY > YMax) begin
                y_fly  = YMax;
                up_fly = 1'b1;
            end else begin
                y_fly = y_w + StepY;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        visible_d = visible_q;
        falling_d = falling_q;
        left_d    = left_q;
        up_d      = up_q;
        escaped_d = 1'b0;
        landed_d  = 1'b0;

        if (bus.state != Play) begin
            // Leaving play parks the duck out of sight with its position held.
            state_d   = StIdle;
            visible_d = 1'b0;
            falling_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (spawn_d_q) begin
                        x_d       = x_load[9:0];
                        y_d       = y_load[9:0];
                        left_d    = bus.spawn_x[0];
                        up_d      = bus.spawn_y[1];
                        visible_d = 1'b1;
                        state_d   = StFly;
                    end
                end
                StFly: begin
                    if (bus.hit) begin
                        state_d   = StFall;
                        falling_d = 1'b1;
                    end else if (bus.timeout) begin
                        state_d = StEscape;
                    end else if (bus.frame_tick) begin
                        x_d    = x_fly[9:0];
                        y_d    = y_fly[9:0];
                        left_d = left_fly;
                        up_d   = up_fly;
                    end
                end
                StFall: begin
                    if (bus.frame_tick) begin
                        if (y_w + FallS >= YMax) begin
                            y_d       = YMax[9:0];
                            landed_d  = 1'b1;
                            visible_d = 1'b0;
                            falling_d = 1'b0;
                            state_d   = StIdle;
                        end else begin
                            y_d = 10'(y_w + FallS);
                        end
                    end
                end
                StEscape: begin
                    // Escape runs past the flight band all the way to the top row.
                    if (bus.frame_tick) begin
                        if (y_w <= FallS) begin
                            y_d       = '0;
                            escaped_d = 1'b1;
                            visible_d = 1'b0;
                            state_d   = StIdle;
                        end else begin
                            y_d = 10'(y_w - FallS);
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            visible_q <= 1'b0;
            falling_q <= 1'b0;
            left_q    <= 1'b0;
            up_q      <= 1'b0;
            escaped_q <= 1'b0;
            landed_q  <= 1'b0;
            spawn_d_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            visible_q <= visible_d;
            falling_q <= falling_d;
            left_q    <= left_d;
            up_q      <= up_d;
            escaped_q <= escaped_d;
            landed_q  <= landed_d;
            spawn_d_q <= bus.spawn;
        end
    end

    assign bus.duck_x       = x_q;
    assign bus.duck_y       = y_q;
    assign bus.duck_visible = visible_q;
    assign bus.duck_falling = falling_q;
    assign bus.dir_left     = left_q;
    assign bus.escaped      = escaped_q;
    assign bus.landed       = landed_q;

endmodule

// File: doc/duck_flight_ctrl.md
Name: duck_flight_ctrl

Overview:
Downstream consumer of the random spawn-position generator. On each spawn event it latches the new horizontal/vertical spawn coordinates and animates the duck sprite across the 960x704 play field once per video frame. The flight has four phases: fly with wall bounce, fall when shot, fly off the top on timeout, and idle. Its outputs drive the duck sprite renderer and the score/round logic.

Parameters:
SCREEN_W, 960, play-field width in pixels
SCREEN_H, 704, play-field height in pixels
DUCK_W, 64, sprite width; x range 0..SCREEN_W-DUCK_W (896)
DUCK_H, 64, sprite height; y range Y_MIN..SCREEN_H-DUCK_H (640)
Y_MIN, 96, top of the flight band
STEP_X, 4, horizontal pixels per frame in FLY
STEP_Y, 2, vertical pixels per frame in FLY
FALL_STEP, 6, pixels per frame in FALL and ESCAPE

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
state  in  2  game state; 2'b01 = PLAY, all other values = not playing
frame_tick  in  1  one-cycle pulse per video frame
spawn  in  1  one-cycle pulse; the generator presents new coordinates one cycle later
spawn_x  in  10  generator horizontal output
spawn_y  in  10  generator vertical output
hit  in  1  one-cycle pulse: shot landed on the duck
timeout  in  1  one-cycle pulse: duck flight time expired
duck_x  out  10  sprite left edge
duck_y  out  10  sprite top edge
duck_visible  out  1  sprite to be drawn
duck_falling  out  1  high in FALL (selects the shot sprite)
dir_left  out  1  horizontal direction, 1 = moving left
escaped  out  1  one-cycle pulse: duck left through the top
landed  out  1  one-cycle pulse: shot duck reached the ground

Behaviour:
- All outputs are registered. States: IDLE, FLY, FALL, ESCAPE.
- Reset: state IDLE; duck_x=0, duck_y=0; duck_visible, duck_falling, dir_left, escaped, landed all 0; dir_up=0; spawn_d=0.
- spawn is delayed one cycle into spawn_d. Coordinates are sampled in the cycle where spawn_d=1. Outputs show the new position 2 cycles after the spawn pulse.
- Load on spawn_d in IDLE with state==PLAY:
  - x = min(spawn_x, 896); y = clamp(spawn_y, 96, 640).
  - dir_left = spawn_x[0]; dir_up = spawn_y[1].
  - duck_visible=1; go to FLY.
  - spawn_d in any other state is ignored.
- FLY, on frame_tick:
  - Moving left: if x < STEP_X then x=0 and dir_left<=0, else x -= STEP_X.
  - Moving right: if x+STEP_X > 896 then x=896 and dir_left<=1, else x += STEP_X.
  - Vertical: same bounce rule on y between 96 and 640 using STEP_Y and dir_up.
  - Use 11-bit intermediate sums; no wrap-around is permitted.
- FLY with hit: go to FALL, duck_falling=1, no movement that cycle, even if frame_tick is also high.
- FLY with timeout (and no hit): go to ESCAPE. Hit has priority over a simultaneous timeout.
- FALL, on frame_tick:
  - If y+FALL_STEP >= 640: y=640, landed pulses for 1 cycle, go to IDLE, duck_visible=0, duck_falling=0.
  - Else y += FALL_STEP. x is frozen.
- ESCAPE, on frame_tick:
  - If y <= FALL_STEP: y=0, escaped pulses for 1 cycle, go to IDLE, duck_visible=0.
  - Else y -= FALL_STEP. x is frozen.
  - The lower bound is 0, not Y_MIN.
- hit and timeout are ignored in IDLE, FALL and ESCAPE.
- state != PLAY in any cycle: next cycle the block is in IDLE with duck_visible=0, duck_falling=0, no escaped/landed pulse, and positions held. A spawn_d in that cycle is ignored.
- Reset mid-flight returns the block to the reset values next cycle, regardless of other inputs.
- In IDLE, duck_x and duck_y hold their last values.

Test Plan:
- Reset, then state=PLAY, spawn with spawn_x=300, spawn_y=200 -> 2 cycles later duck_x=300, duck_y=200, duck_visible=1; dir_left=0, dir_up=0.
- Spawn x=894, moving right; 1 frame_tick -> duck_x=896, dir_left=1; next tick -> duck_x=892.
- spawn_x=1000, spawn_y=50 -> duck_x=896, duck_y=96. Spawn while in FLY -> position unchanged.
- FLY at y=630, hit and timeout in the same cycle as frame_tick -> FALL, y unchanged; 2 ticks -> y=640, landed pulses once, duck_visible=0.
- FLY at y=100, timeout -> ESCAPE; ticks take y through 94, 88, ... until y<=6, then y=0 and escaped pulses for exactly 1 cycle. A hit during ESCAPE has no effect.
- Mid-FLY: state=2'b10 -> IDLE and duck_visible=0 next cycle. Separately, rst mid-FALL -> all outputs return to reset values.
